// File: rtl/polar_dec_pkg.sv
// Shared types and constants for the 2-path list SC polar decoder back end.
package polar_dec_pkg;

    localparam int METRIC_W = 16;
    localparam int MAX_BITS = 64;
    localparam int IDX_W    = 7;

    typedef logic path_idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SELECT  = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

endpackage

// File: rtl/path_store.sv
// Two survivor-path registers with a copy-on-write write port and one read port.
module path_store #(
    parameter int MAX_BITS = polar_dec_pkg::MAX_BITS,
    parameter int IDX_W    = polar_dec_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  polar_dec_pkg::path_idx_t cont_path_0,
    input  polar_dec_pkg::path_idx_t cont_path_1,
    input  logic                     hard_dec_0,
    input  logic                     hard_dec_1,
    input  polar_dec_pkg::path_idx_t rd_sel,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic                     rd_bit
);

    logic [MAX_BITS-1:0] path_0;
    logic [MAX_BITS-1:0] path_1;
    logic [MAX_BITS-1:0] src_0;
    logic [MAX_BITS-1:0] src_1;
    logic [MAX_BITS-1:0] next_0;
    logic [MAX_BITS-1:0] next_1;
    logic [MAX_BITS-1:0] rd_word;

    // Both new paths are built from the pre-update registers, so swaps and duplicates are exact.
    always_comb begin
        src_0  = cont_path_0 ? path_1 : path_0;
        src_1  = cont_path_1 ? path_1 : path_0;
        next_0 = '0;
        next_1 = '0;
        for (int unsigned i = 0; i < MAX_BITS; i++) begin
            if (i < 32'(wr_idx)) begin
                next_0[i] = src_0[i];
                next_1[i] = src_1[i];
            end else if (i == 32'(wr_idx)) begin
                next_0[i] = hard_dec_0;
                next_1[i] = hard_dec_1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            path_0 <= '0;
            path_1 <= '0;
        end else if (clear) begin
            path_0 <= '0;
            path_1 <= '0;
        end else if (wr_en) begin
            path_0 <= next_0;
            path_1 <= next_1;
        end
    end

    always_comb begin
        rd_word = rd_sel ? path_1 : path_0;
        rd_bit  = 1'b0;
        for (int unsigned i = 0; i < MAX_BITS; i++) begin
            if (32'(rd_idx) == i) begin
                rd_bit = rd_word[i];
            end
        end
    end

endmodule

// File: rtl/path_memory.sv
// Survivor-path memory: collects info bits per list path, picks the best metric, streams it out.
module path_memory #(
    parameter int MAX_BITS = polar_dec_pkg::MAX_BITS,
    parameter int IDX_W    = polar_dec_pkg::IDX_W,
    parameter int METRIC_W = polar_dec_pkg::METRIC_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enb,
    input  logic                start,
    input  logic [IDX_W-1:0]    blkLen,
    input  logic                pathWrEn,
    input  logic                hardDecs_0,
    input  logic                hardDecs_1,
    input  logic                contPaths_0,
    input  logic                contPaths_1,
    input  logic [METRIC_W-1:0] metrics_0,
    input  logic [METRIC_W-1:0] metrics_1,
    input  logic                finalize,
    input  logic                outReady,
    output logic                decBit,
    output logic                decValid,
    output logic                decLast,
    output logic                winner,
    output logic [METRIC_W-1:0] winMetric,
    output logic                busy,
    output logic                done,
    output logic                errFlag
);

    import polar_dec_pkg::*;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_SELECT  = SELECT;
    localparam logic [1:0] ST_OUTPUT  = OUTPUT;

    logic [1:0]       state;
    logic [IDX_W-1:0] blk_k;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             blk_ok;
    logic             start_ok;
    logic             collecting;
    logic             wr_room;
    logic             wr_go;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx_next;
    logic             last_beat;
    logic             rd_bit;

    always_comb begin
        blk_ok      = (blkLen != '0) && (int'(blkLen) <= MAX_BITS);
        start_ok    = start && blk_ok;
        collecting  = (state == ST_COLLECT);
        wr_room     = (wr_idx < blk_k);
        wr_go       = collecting && pathWrEn && wr_room;
        wr_en       = enb && !start_ok && wr_go;
        wr_idx_next = wr_idx + IDX_W'(wr_go);
        last_beat   = (rd_idx == blk_k - IDX_W'(1));
    end

    path_store #(
        .MAX_BITS(MAX_BITS),
        .IDX_W   (IDX_W)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .clear      (enb && start_ok),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .cont_path_0(contPaths_0),
        .cont_path_1(contPaths_1),
        .hard_dec_0 (hardDecs_0),
        .hard_dec_1 (hardDecs_1),
        .rd_sel     (winner),
        .rd_idx     (rd_idx),
        .rd_bit     (rd_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            blk_k     <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            winner    <= 1'b0;
            winMetric <= '0;
            done      <= 1'b0;
            errFlag   <= 1'b0;
        end else if (enb) begin
            done <= 1'b0;
            if (start && !blk_ok) begin
                errFlag <= 1'b1;
            end
            if (start_ok) begin
                blk_k   <= blkLen;
                wr_idx  <= '0;
                rd_idx  <= '0;
                errFlag <= 1'b0;
                state   <= ST_COLLECT;
            end else begin
                case (state)
                    ST_COLLECT: begin
                        wr_idx <= wr_idx_next;
                        if (pathWrEn && !wr_room) begin
                            errFlag <= 1'b1;
                        end
                        // Metric compare happens here so winner is already stable during SELECT.
                        if (finalize) begin
                            state     <= ST_SELECT;
                            winner    <= (metrics_1 < metrics_0);
                            winMetric <= (metrics_1 < metrics_0) ? metrics_1 : metrics_0;
                            if (wr_idx_next < blk_k) begin
                                errFlag <= 1'b1;
                            end
                        end
                    end
                    ST_SELECT: begin
                        rd_idx <= '0;
                        state  <= ST_OUTPUT;
                    end
                    ST_OUTPUT: begin
                        if (outReady) begin
                            if (last_beat) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                rd_idx <= rd_idx + IDX_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        decValid = (state == ST_OUTPUT);
        decBit   = decValid && rd_bit;
        decLast  = decValid && last_beat;
        busy     = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_path_memory.sv
// Self-checking bench for path_memory against a queue-based survivor-path model.
module tb_path_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enb = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  blkLen = '0;
    logic        pathWrEn = 1'b0;
    logic        hardDecs_0 = 1'b0;
    logic        hardDecs_1 = 1'b0;
    logic        contPaths_0 = 1'b0;
    logic        contPaths_1 = 1'b0;
    logic [15:0] metrics_0 = '0;
    logic [15:0] metrics_1 = '0;
    logic        finalize = 1'b0;
    logic        outReady = 1'b0;
    logic        decBit;
    logic        decValid;
    logic        decLast;
    logic        winner;
    logic [15:0] winMetric;
    logic        busy;
    logic        done;
    logic        errFlag;

    int n_vec = 0;
    int n_err = 0;

    bit w_hd0 [80];
    bit w_hd1 [80];
    bit w_cp0 [80];
    bit w_cp1 [80];

    path_memory #(
        .MAX_BITS(64),
        .IDX_W   (7),
        .METRIC_W(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .start      (start),
        .blkLen     (blkLen),
        .pathWrEn   (pathWrEn),
        .hardDecs_0 (hardDecs_0),
        .hardDecs_1 (hardDecs_1),
        .contPaths_0(contPaths_0),
        .contPaths_1(contPaths_1),
        .metrics_0  (metrics_0),
        .metrics_1  (metrics_1),
        .finalize   (finalize),
        .outReady   (outReady),
        .decBit     (decBit),
        .decValid   (decValid),
        .decLast    (decLast),
        .winner     (winner),
        .winMetric  (winMetric),
        .busy       (busy),
        .done       (done),
        .errFlag    (errFlag)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_write(input int j, input bit hd0, input bit hd1, input bit cp0, input bit cp1);
        w_hd0[j] = hd0;
        w_hd1[j] = hd1;
        w_cp0[j] = cp0;
        w_cp1[j] = cp1;
    endtask

    task automatic fill_random(input int nw);
        for (int j = 0; j < nw; j++) begin
            set_write(j, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(decValid), 64'(0));
        check({tag, "_bit"}, 64'(decBit), 64'(0));
        check({tag, "_last"}, 64'(decLast), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(errFlag), 64'(0));
        check({tag, "_winner"}, 64'(winner), 64'(0));
        check({tag, "_metric"}, 64'(winMetric), 64'(0));
    endtask

    // One full codeword: start, writes from w_* tables, finalize, drain with handshake.
    task automatic run_cw(input int k, input int nw, input bit fin_last, input bit enb_gap,
                          input int stall_at, input int stall_len, input bit rnd_ready,
                          input logic [15:0] m0, input logic [15:0] m1);
        bit q0[$];
        bit q1[$];
        bit t0[$];
        bit t1[$];
        bit merr;
        bit mwin;
        logic [15:0] mmet;
        bit exp_bit;
        bit rdy;
        int i;
        int cyc;
        int stalled;
        merr = 1'b0;
        blkLen = 7'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_err", 64'(errFlag), 64'(0));
        check("start_valid", 64'(decValid), 64'(0));
        if (enb_gap) begin
            enb = 1'b0;
            pathWrEn = 1'b1;
            hardDecs_0 = 1'b1;
            hardDecs_1 = 1'b1;
            repeat (2) @(negedge clk);
            pathWrEn = 1'b0;
            enb = 1'b1;
        end
        for (int j = 0; j < nw; j++) begin
            hardDecs_0 = w_hd0[j];
            hardDecs_1 = w_hd1[j];
            contPaths_0 = w_cp0[j];
            contPaths_1 = w_cp1[j];
            pathWrEn = 1'b1;
            finalize = fin_last && (j == nw - 1);
            metrics_0 = finalize ? m0 : 16'($urandom);
            metrics_1 = finalize ? m1 : 16'($urandom);
            @(negedge clk);
            pathWrEn = 1'b0;
            finalize = 1'b0;
            if (q0.size() < k) begin
                t0 = w_cp0[j] ? q1 : q0;
                t1 = w_cp1[j] ? q1 : q0;
                t0.push_back(w_hd0[j]);
                t1.push_back(w_hd1[j]);
                q0 = t0;
                q1 = t1;
            end else begin
                merr = 1'b1;
            end
        end
        if (!(fin_last && nw > 0)) begin
            finalize = 1'b1;
            metrics_0 = m0;
            metrics_1 = m1;
            @(negedge clk);
            finalize = 1'b0;
        end
        metrics_0 = 16'($urandom);
        metrics_1 = 16'($urandom);
        if (q0.size() < k) merr = 1'b1;
        mwin = (m1 < m0);
        mmet = mwin ? m1 : m0;
        check("sel_valid", 64'(decValid), 64'(0));
        check("sel_busy", 64'(busy), 64'(1));
        check("sel_winner", 64'(winner), 64'(mwin));
        check("sel_metric", 64'(winMetric), 64'(mmet));
        @(negedge clk);
        i = 0;
        cyc = 0;
        stalled = 0;
        while (i < k && cyc < k + 64) begin
            if (mwin) exp_bit = (i < q1.size()) ? q1[i] : 1'b0;
            else      exp_bit = (i < q0.size()) ? q0[i] : 1'b0;
            check("out_valid", 64'(decValid), 64'(1));
            check("out_bit", 64'(decBit), 64'(exp_bit));
            check("out_last", 64'(decLast), 64'(i == k - 1));
            if (i == stall_at && stalled < stall_len) rdy = 1'b0;
            else if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'b1;
            outReady = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) i++;
            else if (i == stall_at) stalled++;
        end
        outReady = 1'b0;
        check("out_count", 64'(i), 64'(k));
        check("done_pulse", 64'(done), 64'(1));
        check("end_valid", 64'(decValid), 64'(0));
        check("end_busy", 64'(busy), 64'(0));
        check("end_err", 64'(errFlag), 64'(merr));
        @(negedge clk);
        check("done_clear", 64'(done), 64'(0));
    endtask

    initial begin
        int k;
        int nw;
        logic [15:0] m0;
        logic [15:0] m1;

        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // basic copy/select, then the same with a 3-cycle stall at bit 2
        for (int pass = 0; pass < 2; pass++) begin
            set_write(0, 1, 0, 0, 0);
            set_write(1, 1, 1, 1, 0);
            set_write(2, 0, 1, 0, 0);
            set_write(3, 1, 0, 1, 1);
            run_cw(4, 4, 0, 0, (pass == 0) ? 99 : 2, 3, 0, 16'h0040, 16'h0020);
        end

        // tie and duplicate
        set_write(0, 0, 1, 0, 0);
        set_write(1, 1, 1, 1, 1);
        run_cw(2, 2, 0, 0, 99, 0, 0, 16'h0010, 16'h0010);

        // overflow, underrun, write+finalize in one cycle, enb gap
        fill_random(3);
        run_cw(2, 3, 0, 0, 99, 0, 0, 16'h0100, 16'h0200);
        fill_random(1);
        run_cw(3, 1, 0, 0, 99, 0, 0, 16'h0300, 16'h0200);
        fill_random(5);
        run_cw(5, 5, 1, 0, 99, 0, 1, 16'h0007, 16'h0009);
        fill_random(2);
        run_cw(2, 2, 0, 1, 99, 0, 0, 16'h0050, 16'h0060);

        // invalid starts from IDLE
        for (int b = 0; b < 2; b++) begin
            blkLen = (b == 0) ? 7'd0 : 7'd65;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("bad_start_err", 64'(errFlag), 64'(1));
            check("bad_start_busy", 64'(busy), 64'(0));
        end

        // abort in OUTPUT by a new start
        blkLen = 7'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hardDecs_0 = 1'b1;
        contPaths_0 = 1'b0;
        contPaths_1 = 1'b0;
        pathWrEn = 1'b1;
        @(negedge clk);
        pathWrEn = 1'b0;
        finalize = 1'b1;
        @(negedge clk);
        finalize = 1'b0;
        @(negedge clk);
        check("abort_pre_valid", 64'(decValid), 64'(1));
        check("abort_pre_err", 64'(errFlag), 64'(1));
        fill_random(4);
        run_cw(4, 4, 0, 0, 99, 0, 1, 16'($urandom), 16'($urandom));

        // async reset during COLLECT, with an invalid start first setting errFlag
        blkLen = 7'd4;
        start = 1'b1;
        @(negedge clk);
        blkLen = 7'd0;
        @(negedge clk);
        start = 1'b0;
        check("collect_bad_err", 64'(errFlag), 64'(1));
        check("collect_bad_busy", 64'(busy), 64'(1));
        pathWrEn = 1'b1;
        @(negedge clk);
        pathWrEn = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // block-length boundaries and random codewords
        for (int n = 0; n < 24; n++) begin
            if (n == 0) k = 1;
            else if (n == 1) k = 64;
            else k = $urandom_range(1, 64);
            case ($urandom_range(0, 5))
                0:       nw = k + 1;
                1:       nw = $urandom_range(0, k - 1);
                default: nw = k;
            endcase
            m0 = 16'($urandom);
            m1 = ($urandom_range(0, 3) == 0) ? m0 : 16'($urandom);
            fill_random(nw);
            run_cw(k, nw, 1'($urandom), (n % 7) == 3, 99, 0, 1, m0, m1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
